// File: rtl/tof_i2c_pkg.sv
// Shared definitions for the ToF I2C sequencer: FSM state encoding,
// default sensor address and command length width.
// Ports: none (package).
package tof_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_XFER      = 3'd3,
    ST_STOP_WAIT = 3'd4,
    ST_ABORT     = 3'd5
  } state_t;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h29;

  // Byte count 1..256 needs 9 bits; the remaining count uses the same width.
  localparam int LEN_W = 9;

endpackage

// File: rtl/tof_i2c_timeout.sv
// Watchdog: counts cycles while run is high, restarts from zero on load.
// Latency: expired rises combinationally once TIMEOUT_CYCLES run cycles have started since load.
// Backpressure: none; the counter saturates until the next load.
// Ports: clock, reset (async active-high), load (restart), run (count enable), expired.
module tof_i2c_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // expired is flagged during the TIMEOUT_CYCLES-th cycle so the owner reacts
  // on the clock edge that completes that many cycles.
  assign expired = run && (count >= CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tof_i2c_sequencer.sv
// Sequences one ToF sensor register read/write per command through a byte-level I2C engine.
// Latency: read cmd to i2c_start 2 cycles; write starts 1 cycle after its first byte; rd_valid 1 cycle after an engine ready edge.
// Backpressure: cmd_ready only in IDLE; wr_ready only while the single-byte hold register is empty.
// Ports: cmd_* command channel, wr_* write byte stream, rd_* read byte stream, done/error status,
//        i2c_* engine control/data, clock and async active-high reset.
module tof_i2c_sequencer
  import tof_i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR     = DEFAULT_SLAVE_ADDR,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_is_read,
  input  logic [15:0]      cmd_reg_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             error,
  output logic             i2c_start,
  output logic             i2c_reset,
  output logic [6:0]       i2c_slave_address,
  output logic [15:0]      i2c_register_address,
  output logic             i2c_is_read,
  output logic [16:0]      i2c_nb_of_bytes,
  output logic [7:0]       i2c_data_in,
  input  logic [7:0]       i2c_data_out,
  input  logic             i2c_ready,
  input  logic             i2c_error
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] rem;
  logic [7:0]       hold_dat;
  logic             hold_full;
  logic             rdy_q;
  logic             rdy_edge;
  logic             done_pend;
  logic             abort_cnt;
  logic             accept;
  logic             capture;
  logic             abort_now;
  logic             xfer_edge;
  logic             stop_edge;
  logic             wd_load;
  logic             wd_run;
  logic             wd_expired;

  assign rdy_edge  = i2c_ready & ~rdy_q;
  assign accept    = cmd_valid & cmd_ready;
  assign capture   = wr_valid & wr_ready & ~abort_now;
  assign xfer_edge = (state == ST_XFER) && rdy_edge && !abort_now;
  assign stop_edge = (state == ST_STOP_WAIT) && rdy_edge && !abort_now;

  assign wd_load = rdy_edge || (state == ST_START);
  assign wd_run  = (state == ST_XFER) || (state == ST_STOP_WAIT);

  assign i2c_slave_address = SLAVE_ADDR;
  assign i2c_nb_of_bytes   = {8'd0, rem};
  assign i2c_data_in       = hold_dat;

  tof_i2c_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .load   (wd_load),
    .run    (wd_run),
    .expired(wd_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    i2c_start = 1'b0;
    i2c_reset = 1'b0;
    abort_now = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Held off for the one cycle between a final rd_valid and its done.
        cmd_ready = !done_pend;
        if (cmd_valid && !done_pend && cmd_len != '0) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        wr_ready = !i2c_is_read;
        if (i2c_error)                     abort_now = 1'b1;
        else if (i2c_is_read || wr_valid)  state_nxt = ST_START;
      end
      ST_START: begin
        i2c_start = 1'b1;
        if (i2c_error) abort_now = 1'b1;
        else           state_nxt = ST_XFER;
      end
      ST_XFER: begin
        wr_ready = !i2c_is_read && !hold_full;
        // An edge outranks a watchdog expiry in the same cycle.
        if (i2c_error) begin
          abort_now = 1'b1;
        end else if (rdy_edge) begin
          if (!i2c_is_read && !hold_full) abort_now = 1'b1;   // write underrun
          else if (rem == '0)             state_nxt = ST_STOP_WAIT;
        end else if (wd_expired) begin
          abort_now = 1'b1;
        end
      end
      ST_STOP_WAIT: begin
        if (i2c_error)       abort_now = 1'b1;
        else if (rdy_edge)   state_nxt = ST_IDLE;
        else if (wd_expired) abort_now = 1'b1;
      end
      ST_ABORT: begin
        i2c_reset = 1'b1;
        if (abort_cnt) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_now) state_nxt = ST_ABORT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy_q                <= 1'b0;
      rem                  <= '0;
      hold_dat             <= '0;
      hold_full            <= 1'b0;
      done_pend            <= 1'b0;
      abort_cnt            <= 1'b0;
      rd_data              <= '0;
      rd_valid             <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
      i2c_register_address <= '0;
      i2c_is_read          <= 1'b0;
    end else begin
      rdy_q     <= i2c_ready;
      rd_valid  <= 1'b0;
      done      <= done_pend;
      done_pend <= 1'b0;
      abort_cnt <= (state == ST_ABORT) ? ~abort_cnt : 1'b0;

      if (accept) begin
        if (cmd_len == '0) begin
          error <= 1'b1;
          done  <= 1'b1;
        end else begin
          error                <= 1'b0;
          rem                  <= cmd_len - 1'b1;
          hold_full            <= 1'b0;
          i2c_register_address <= cmd_reg_addr;
          i2c_is_read          <= cmd_is_read;
        end
      end

      if (abort_now) error <= 1'b1;

      if (capture) begin
        hold_dat  <= wr_data;
        hold_full <= 1'b1;
      end

      if (xfer_edge) begin
        if (rem != '0) rem <= rem - 1'b1;
        if (!i2c_is_read) begin
          hold_full <= 1'b0;
        end else if (rem != '0) begin
          // The rem==0 edge closes the last byte; that byte is reported at stop.
          rd_data  <= i2c_data_out;
          rd_valid <= 1'b1;
        end
      end

      if (stop_edge) begin
        if (i2c_is_read) begin
          rd_data   <= i2c_data_out;
          rd_valid  <= 1'b1;
          done_pend <= 1'b1;
        end else begin
          done <= 1'b1;
        end
      end

      if ((state == ST_ABORT) && abort_cnt) done <= 1'b1;
    end
  end

endmodule
